// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: one port shared by the CPU MEM stage and a DMA master.
// CPU wins by default; a DMA request denied STARVE_LIMIT cycles in a row is forced ahead.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic [31:0]       dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    logic [3:0] starve_cnt;
    logic       dma_first;
    logic       cpu_gnt;
    logic       tag_valid;
    logic       tag_dma;

    assign dma_first = (starve_cnt >= 4'(STARVE_LIMIT));

    // Grants are suppressed while reset is high so nothing reaches memory.
    always_comb begin
        cpu_gnt   = ~reset & cpu_req & ~(dma_req & dma_first);
        dma_gnt   = ~reset & dma_req & ~cpu_gnt;
        cpu_stall = ~reset & cpu_req & ~cpu_gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_read  = ~dma_we;
            mem_write = dma_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            tag_valid  <= 1'b0;
            tag_dma    <= 1'b0;
        end else begin
            if (dma_req && !dma_gnt)
                starve_cnt <= (starve_cnt == 4'd15) ? 4'd15 : starve_cnt + 4'd1;
            else
                starve_cnt <= '0;
            tag_valid <= mem_read;
            tag_dma   <= dma_gnt;
        end
    end

    // A read in flight when reset rises is dropped rather than returned.
    always_comb begin
        cpu_rvalid = ~reset & tag_valid & ~tag_dma;
        dma_rvalid = ~reset & tag_valid & tag_dma;
        cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
        dma_rdata  = dma_rvalid ? mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter, checked against a transaction-level
// model of grant priority, starvation and one-cycle read return.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_read, mem_write;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int failures = 0;

    logic [31:0] dev_mem [256];
    logic [31:0] ref_mem [256];

    int          starve;
    bit          pv, po;
    logic [31:0] pd;
    bit          eg_c, eg_d, e_read, e_write;
    logic [31:0] e_addr, e_wdata;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read data memory: data appears the cycle after mem_read.
    always @(posedge clk) begin
        if (mem_write) dev_mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= dev_mem[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit cq, input bit cw, input logic [31:0] ca,
                         input logic [31:0] cd, input bit dq, input bit dw,
                         input logic [31:0] da, input logic [31:0] dd);
        bit e_crv, e_drv;
        reset = r; cpu_req = cq; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dq; dma_we = dw; dma_addr = da; dma_wdata = dd;
        #1;
        eg_c    = !r && cq && !(dq && starve >= LIMIT);
        eg_d    = !r && dq && !eg_c;
        e_addr  = eg_c ? ca : (eg_d ? da : 32'd0);
        e_wdata = eg_c ? cd : (eg_d ? dd : 32'd0);
        e_read  = (eg_c && !cw) || (eg_d && !dw);
        e_write = (eg_c && cw) || (eg_d && dw);
        e_crv   = !r && pv && !po;
        e_drv   = !r && pv && po;
        chk("cpu_stall", cpu_stall, !r && cq && !eg_c);
        chk("dma_gnt", dma_gnt, eg_d);
        chk("mem_read", mem_read, e_read);
        chk("mem_write", mem_write, e_write);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("cpu_rvalid", cpu_rvalid, e_crv);
        chk("cpu_rdata", cpu_rdata, e_crv ? pd : 32'd0);
        chk("dma_rvalid", dma_rvalid, e_drv);
        chk("dma_rdata", dma_rdata, e_drv ? pd : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            starve = 0;
            pv = 0;
        end else begin
            pv = e_read;
            po = eg_d;
            pd = ref_mem[e_addr[9:2]];
            if (e_write) ref_mem[e_addr[9:2]] = e_wdata;
            if (dma_req && !eg_d) starve = (starve >= 15) ? 15 : starve + 1;
            else starve = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit          c_act, d_act, c_we, d_we, r;
        logic [31:0] c_addr, c_wd, d_addr, d_wd;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = (i * 32'h01010101) ^ 32'hDEADBEEF;
            ref_mem[i] = (i * 32'h01010101) ^ 32'hDEADBEEF;
        end
        starve = 0; pv = 0; po = 0; pd = 0;
        reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        @(negedge clk);

        // Reset with both requesters active: no strobes, no grant, no stall.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 32'h10, 32'h1, 1, 1, 32'h14, 32'h2);
            chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
            tick();
        end
        idle();
        chk("idle_addr", mem_addr, 32'd0);
        tick();

        // CPU write then read-back of the same word.
        drive(0, 1, 1, 32'h10, 32'h12345678, 0, 0, 0, 0);
        chk("wr_strobe", mem_write, 1'b1);
        tick();
        drive(0, 1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        chk("rd_strobe", mem_read, 1'b1);
        tick();
        idle();
        chk("rb_rvalid", cpu_rvalid, 1'b1);
        chk("rb_rdata", cpu_rdata, 32'h12345678);
        tick();

        // Continuous contention: DMA forced ahead after LIMIT denials.
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);
            if (i < LIMIT) begin
                chk("starve_dgnt", dma_gnt, 1'b0);
                chk("starve_stall", cpu_stall, 1'b0);
            end else if (i == LIMIT) begin
                chk("forced_dgnt", dma_gnt, 1'b1);
                chk("forced_stall", cpu_stall, 1'b1);
            end else begin
                chk("cleared_dgnt", dma_gnt, 1'b0);
            end
            tick();
        end
        idle();
        tick();

        // Alternating owners, each return routed only to its owner.
        drive(0, 1, 0, 32'h20, 32'h0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 32'h24, 32'h0);
        chk("alt_crv", cpu_rvalid, 1'b1);
        chk("alt_crd", cpu_rdata, ref_mem[8]);
        tick();
        idle();
        chk("alt_drv", dma_rvalid, 1'b1);
        chk("alt_crv2", cpu_rvalid, 1'b0);
        chk("alt_drd", dma_rdata, ref_mem[9]);
        tick();

        // DMA read in flight is discarded by reset.
        drive(0, 0, 0, 0, 0, 1, 0, 32'h30, 32'h0);
        tick();
        drive(1, 1, 0, 32'h34, 0, 1, 0, 32'h38, 32'h0);
        chk("flush_drv", dma_rvalid, 1'b0);
        tick();
        idle();
        chk("flush_drv2", dma_rvalid, 1'b0);
        tick();

        // Lone DMA write.
        drive(0, 0, 0, 0, 0, 1, 1, 32'h1FC, 32'hA5A5A5A5);
        chk("dwr_gnt", dma_gnt, 1'b1);
        chk("dwr_stall", cpu_stall, 1'b0);
        tick();
        idle();
        chk("dwr_norv", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
        tick();

        // Randomized traffic obeying the hold-until-granted protocol.
        c_act = 0; d_act = 0;
        c_we = 0; d_we = 0; c_addr = 0; d_addr = 0; c_wd = 0; d_wd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!c_act && ($urandom_range(2) != 0)) begin
                c_act = 1; c_we = $urandom_range(1) == 1;
                c_addr = {22'd0, 8'($urandom), 2'b00}; c_wd = $urandom;
            end
            if (!d_act && ($urandom_range(3) != 0)) begin
                d_act = 1; d_we = $urandom_range(1) == 1;
                d_addr = {22'd0, 8'($urandom), 2'b00}; d_wd = $urandom;
            end
            r = ($urandom_range(39) == 0);
            drive(r, c_act, c_act ? c_we : 1'($urandom), c_act ? c_addr : $urandom,
                  c_act ? c_wd : $urandom, d_act, d_act ? d_we : 1'($urandom),
                  d_act ? d_addr : $urandom, d_act ? d_wd : $urandom);
            if (eg_c) c_act = 0;
            if (eg_d) d_act = 0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles a DMA request may be denied before it is forced ahead of the CPU (range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the width of all byte addresses.
REQ-003 SHALL use clock clk, with reset reset synchronous and active-high.
REQ-004 SHALL have ports as follows:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU MEM-stage access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  write data.
- cpu_stall  out  1  CPU request pending but not granted this cycle.
- cpu_rdata  out  32  read data.
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- dma_req  in  1  DMA/peripheral access request.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  ADDR_W  byte address.
- dma_wdata  in  32  write data.
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rdata  out  32  read data.
- dma_rvalid  out  1  dma_rdata valid this cycle.
- mem_addr  out  ADDR_W  address to the data memory.
- mem_wdata  out  32  write data to the data memory.
- mem_read  out  1  read strobe to the data memory.
- mem_write  out  1  write strobe to the data memory.
- mem_rdata  in  32  data memory registered read data, valid one cycle after mem_read.

Function
REQ-005 SHALL issue at most one memory access per cycle; grant decisions and the mem_* outputs are combinational from the current requests and registered state.
REQ-006 SHALL, by default, give the CPU fixed priority when both cpu_req and dma_req are high.
REQ-007 SHALL keep a 4-bit starve counter: increment (saturating at 15) each cycle dma_req=1 and dma_gnt=0; clear on dma_gnt=1 or dma_req=0.
REQ-008 SHALL grant DMA over CPU when starve counter >= STARVE_LIMIT.
REQ-009 SHALL assert cpu_stall = cpu_req & ~CPU-granted; requesters SHALL hold req/we/addr/wdata stable until granted (CPU: until cpu_stall=0; DMA: until dma_gnt=1).
REQ-010 SHALL drive for the granted requester: mem_addr = its addr, mem_wdata = its wdata, mem_write = we, mem_read = ~we.
REQ-011 SHALL, when there is no grant, drive mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-012 SHALL register a read-return tag {valid, owner} each cycle from the current read grant; the next cycle routes mem_rdata to the owner's rdata and pulses that owner's rvalid for exactly one cycle.
REQ-013 SHALL drive rdata of a non-owner to 0 with its rvalid=0; rvalid SHALL never be asserted for writes.
REQ-014 SHALL support back-to-back reads: a grant in cycle N returns data in N+1 while a new grant is issued in N+1; the tag pipeline has no bubble.
REQ-015 SHALL have no read-after-write hazard handling beyond memory ordering: a write in cycle N followed by a read of the same address in N+1 returns the new data.
REQ-016 SHALL ignore cpu_we/addr/wdata when cpu_req=0, and likewise for DMA.

Reset
REQ-017 SHALL, with reset=1 on a clock edge, clear the starve counter and the read tag; cycle after: cpu_rvalid=0, dma_rvalid=0, cpu_rdata=0, dma_rdata=0.
REQ-018 SHALL force mem_read=0, mem_write=0, dma_gnt=0 and cpu_stall=0 during any cycle reset=1, regardless of requests.
REQ-019 SHALL discard a read in flight when reset is asserted: no rvalid pulse follows reset.

Verification
REQ-020 SHALL pass: CPU write 0x12345678 to 0x10, then CPU read 0x10 -> mem_write in cycle 0; mem_read in cycle 1; cpu_rvalid=1, cpu_rdata=0x12345678 in cycle 2.
REQ-021 SHALL pass: cpu_req and dma_req continuously high, both reads, STARVE_LIMIT=4 -> CPU granted cycles 0-3, dma_gnt=1 in cycle 4, CPU stalled in cycle 4, counter cleared.
REQ-022 SHALL pass: alternating CPU read 0x20 (cycle 0) and DMA read 0x24 (cycle 1) -> cpu_rvalid in cycle 1 only, dma_rvalid in cycle 2 only, each with its own data.
REQ-023 SHALL pass: DMA read granted in cycle 5, reset=1 in cycle 6 -> dma_rvalid=0 in cycles 6-7, all mem strobes 0 in cycle 6.
REQ-024 SHALL pass: DMA alone writes 0xA5A5A5A5 to 0x1FC -> dma_gnt=1 same cycle, cpu_stall=0, no rvalid pulses.
REQ-025 SHALL pass: no requests -> all mem_* outputs 0 and starve counter 0.
